dec_unbinder: RTL and testbench
===============================

# dec_unbinder

Feature-serial unbinder/decoder for the sparse HDC datapath. It is the inverse of the encoder's binder stage. The encoder rotates each feature's level hypervector left by a per-feature shift. This block takes one bound query hypervector and, for each feature, rotates it back right by that feature's shift. It then scores the result against every level hypervector (popcount of bitwise AND) and streams out the best-matching level index per feature. It sits after the bundled query register and feeds level-recovery / reconstruction logic.

## Interface
- HV_DIM, default 1024: hypervector width in bits.
- FEATURES, default 16: number of features to decode per query.
- LEVELS, default 8: number of level hypervectors.
- SHIFT_STEP, default 1: shift unit. Feature i uses S_i = (i*SHIFT_STEP) mod HV_DIM, matching the encoder's binder shifts.
- Derived: SW = $clog2(HV_DIM+1), FW = $clog2(FEATURES), LW = $clog2(LEVELS).

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  begin decoding; sampled only in IDLE.
- query_hv  in  HV_DIM  bound query; captured on accepted start.
- level_hv  in  HV_DIM x [0:LEVELS-1]  level item memory; must be stable while busy.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- feat_idx  out  FW  feature index of current result.
- level_idx  out  LW  best-matching level.
- score  out  SW  overlap popcount of the best level.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- Rotation convention: the encoder produces enc[(j+S) mod D] = lvl[j]. This block computes unb[j] = q[(j+S_i) mod D], i.e. a right rotation by S_i.
- States:
  - IDLE: start=1 captures query_hv into q_reg, clears the feature counter f=0, and goes to UNBIND.
  - UNBIND: registers unb_reg = rotr(q_reg, S_f), clears best_score=0, best_idx=0 and level counter l=0, then goes to SCAN.
  - SCAN: one level per cycle. Computes s = popcount(unb_reg & level_hv[l]). If s > best_score, updates best_score and best_idx. Strict greater-than means ties keep the lower index. After l = LEVELS-1, goes to EMIT.
  - EMIT: asserts out_valid with feat_idx=f, level_idx=best_idx, score=best_score. On out_valid && out_ready:
    - if f < FEATURES-1: f++ and go to UNBIND;
    - else: go to IDLE and pulse done.
- Outputs are registered. They are stable while out_valid=1 and out_ready=0, and no state advances during that wait.
- start is ignored while busy. query_hv is not re-sampled mid-query.
- Score arithmetic is unsigned, width SW, and cannot overflow (max HV_DIM).

## Timing
- Reset value of every output is 0: out_valid, feat_idx, level_idx, score, busy, done. State goes to IDLE and all counters and registers are cleared.
- Asserting nrst mid-operation aborts immediately (asynchronously). No partial result is emitted and no done pulse is generated.
- Cycle numbering: start is accepted at edge 0.
  - busy=1 from cycle 1.
  - UNBIND occupies cycle 1; SCAN occupies cycles 2..LEVELS+1.
  - out_valid rises at cycle LEVELS+2.
- Per-feature latency with out_ready held high is LEVELS+2 cycles. The handshake in EMIT moves to the next UNBIND on the following cycle, with no bubble beyond that.
- With out_ready held high, the last EMIT falls in cycle FEATURES*(LEVELS+2). done=1 and busy=0 in cycle FEATURES*(LEVELS+2)+1.
- A new start is accepted in the cycle done is high, since the state is IDLE.
- If start and nrst deassertion coincide, start is not accepted until nrst has been high for one full edge.

## Test plan
Configuration for all scenarios: HV_DIM=16, FEATURES=4, LEVELS=4, SHIFT_STEP=3. Levels are L0=16'h000F, L1=16'h0F00, L2=16'h00F0, L3=16'hF000.

1. Single-feature recovery: query=16'h0780, out_ready=1.
   - Feature 1 (S=3) unbinds to 16'h00F0 -> level_idx=2, score=4.
   - Feature 0 (S=0) -> level_idx=1, score=3.
2. Ties and all-zero query: query=16'h0000 -> four results, all level_idx=0, score=0, feat_idx 0,1,2,3 in order.
3. Backpressure: out_ready=0 for 5 cycles at the first EMIT.
   - out_valid, feat_idx=0, level_idx and score remain constant.
   - busy stays high and the feature counter does not advance.
   - After out_ready rises, feat_idx=1 appears LEVELS+2=6 cycles later.
4. Full-run latency: start at edge 0 with out_ready=1.
   - out_valid at cycles 6, 12, 18, 24.
   - done pulse (one cycle) and busy=0 at cycle 25.
5. Start while busy: pulse start with a different query_hv at cycle 3.
   - Results match the first query only; exactly one done pulse.
6. Reset mid-scan: assert nrst at cycle 4.
   - All outputs read 0 immediately; no done pulse.
   - A fresh start after release produces the scenario-1 results.

Source files
------------

// File: rtl/dec_unbinder.sv
// Feature-serial unbinder: rotates the bound query right per feature, scans all levels, emits best level per feature.
// Latency LEVELS+2 cycles per feature; out_valid holds with outputs frozen while out_ready is low.
module dec_unbinder #(
  parameter int HV_DIM     = 1024,
  parameter int FEATURES   = 16,
  parameter int LEVELS     = 8,
  parameter int SHIFT_STEP = 1,
  localparam int SW = $clog2(HV_DIM + 1),
  localparam int FW = (FEATURES > 1) ? $clog2(FEATURES) : 1,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [HV_DIM-1:0] query_hv,
  input  logic [HV_DIM-1:0] level_hv [0:LEVELS-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FW-1:0]     feat_idx,
  output logic [LW-1:0]     level_idx,
  output logic [SW-1:0]     score,
  output logic              busy,
  output logic              done
);

  localparam int STEP_MOD = SHIFT_STEP % HV_DIM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNBIND,
    S_SCAN,
    S_EMIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HV_DIM-1:0] q_reg;
  logic [HV_DIM-1:0] unb_reg;
  logic [HV_DIM-1:0] unb_nxt;
  logic [FW-1:0]     feat_cnt;
  logic [LW-1:0]     lvl_cnt;
  logic [SW-1:0]     shift_amt;
  logic [SW-1:0]     shift_nxt;
  logic [SW:0]       shift_sum;
  logic [SW-1:0]     best_score;
  logic [LW-1:0]     best_idx;
  logic [SW-1:0]     lvl_score;
  logic              handshake;
  logic              last_feat;
  logic              last_lvl;

  function automatic logic [SW-1:0] popcount(input logic [HV_DIM-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DIM; i++) begin
      c = c + SW'(v[i]);
    end
    return c;
  endfunction

  assign handshake = (state == S_EMIT) && out_ready;
  assign last_feat = (feat_cnt == FW'(FEATURES - 1));
  assign last_lvl  = (lvl_cnt == LW'(LEVELS - 1));

  // Right rotation by S: unb[j] = q[(j+S) mod D]; a shift of D yields zero, covering S=0.
  assign unb_nxt   = (q_reg >> shift_amt) | (q_reg << (SW'(HV_DIM) - shift_amt));
  assign lvl_score = popcount(unb_reg & level_hv[lvl_cnt]);

  // Shift for the next feature tracked incrementally instead of multiplying f*SHIFT_STEP.
  always_comb begin
    shift_sum = {1'b0, shift_amt} + (SW+1)'(STEP_MOD);
    shift_nxt = SW'(shift_sum);
    if (shift_sum >= (SW+1)'(HV_DIM)) begin
      shift_nxt = SW'(shift_sum - (SW+1)'(HV_DIM));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNBIND;
      S_UNBIND: state_nxt = S_SCAN;
      S_SCAN:   if (last_lvl) state_nxt = S_EMIT;
      S_EMIT:   if (handshake) state_nxt = last_feat ? S_IDLE : S_UNBIND;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q_reg      <= '0;
      unb_reg    <= '0;
      feat_cnt   <= '0;
      lvl_cnt    <= '0;
      shift_amt  <= '0;
      best_score <= '0;
      best_idx   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_valid <= (state_nxt == S_EMIT);
      busy      <= (state_nxt != S_IDLE);
      done      <= handshake && last_feat;
      case (state)
        S_IDLE: begin
          if (start) begin
            q_reg     <= query_hv;
            feat_cnt  <= '0;
            shift_amt <= '0;
          end
        end
        S_UNBIND: begin
          unb_reg    <= unb_nxt;
          best_score <= '0;
          best_idx   <= '0;
          lvl_cnt    <= '0;
        end
        S_SCAN: begin
          // Strict compare so ties keep the lower level index.
          if (lvl_score > best_score) begin
            best_score <= lvl_score;
            best_idx   <= lvl_cnt;
          end
          lvl_cnt <= lvl_cnt + LW'(1);
        end
        S_EMIT: begin
          if (handshake && !last_feat) begin
            feat_cnt  <= feat_cnt + FW'(1);
            shift_amt <= shift_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign feat_idx  = feat_cnt;
  assign level_idx = best_idx;
  assign score     = best_score;

endmodule

// File: tb/tb_dec_unbinder.sv
// Directed bench for dec_unbinder at HV_DIM=16, FEATURES=4, LEVELS=4, SHIFT_STEP=3.
module tb_dec_unbinder;

  localparam int D  = 16;
  localparam int F  = 4;
  localparam int L  = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [D-1:0] query_hv = '0;
  logic [D-1:0] level_hv [0:L-1];
  logic         out_valid;
  logic [1:0]   feat_idx;
  logic [1:0]   level_idx;
  logic [4:0]   score;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;

  dec_unbinder #(
    .HV_DIM(D), .FEATURES(F), .LEVELS(L), .SHIFT_STEP(ST)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .query_hv(query_hv),
    .level_hv(level_hv), .out_valid(out_valid), .out_ready(out_ready),
    .feat_idx(feat_idx), .level_idx(level_idx), .score(score),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
  endtask

  task automatic do_start(input logic [D-1:0] q);
    query_hv = q;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    done_cnt = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, int'(out_valid), 1);
  endtask

  // Drains all features with out_ready high; optional check of EMIT cycle numbers.
  task automatic collect(input string tag, input int lv [4], input int sc [4], input bit timed);
    for (int f = 0; f < F; f++) begin
      wait_valid(tag);
      if (timed) chk({tag, "_cyc"}, cyc, 6 * (f + 1));
      chk({tag, "_feat"}, int'(feat_idx), f);
      chk({tag, "_lvl"}, int'(level_idx), lv[f]);
      chk({tag, "_score"}, int'(score), sc[f]);
      tick();
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    if (timed) chk({tag, "_done_cyc"}, cyc, 25);
  endtask

  initial begin
    int n;
    int exp_lv1 [4] = '{1, 2, 0, 0};
    int exp_sc1 [4] = '{3, 4, 3, 2};
    int exp_lv0 [4] = '{0, 0, 0, 0};
    int exp_sc0 [4] = '{0, 0, 0, 0};

    level_hv[0] = 16'h000F;
    level_hv[1] = 16'h0F00;
    level_hv[2] = 16'h00F0;
    level_hv[3] = 16'hF000;

    tick();
    tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_feat", int'(feat_idx), 0);
    chk("rst_lvl", int'(level_idx), 0);
    chk("rst_score", int'(score), 0);
    nrst = 1'b1;
    tick();

    // Recovery with full-run latency, then back-to-back start in the done cycle.
    out_ready = 1'b1;
    do_start(16'h0780);
    chk("s1_busy", int'(busy), 1);
    collect("s1", exp_lv1, exp_sc1, 1'b1);
    chk("s1_done_cnt", done_cnt, 1);

    do_start(16'h0000);
    chk("s2_busy", int'(busy), 1);
    collect("s2", exp_lv0, exp_sc0, 1'b1);
    tick();
    chk("s2_done_pulse", int'(done), 0);

    // Backpressure on the first EMIT.
    out_ready = 1'b0;
    do_start(16'h0780);
    wait_valid("s3");
    chk("s3_cyc", cyc, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_hold_valid", int'(out_valid), 1);
      chk("s3_hold_feat", int'(feat_idx), 0);
      chk("s3_hold_lvl", int'(level_idx), 1);
      chk("s3_hold_score", int'(score), 3);
      chk("s3_hold_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("s3_resume_lat", n, 6);
    chk("s3_feat1", int'(feat_idx), 1);
    chk("s3_lvl1", int'(level_idx), 2);
    chk("s3_score1", int'(score), 4);
    tick();
    for (int f = 2; f < F; f++) begin
      wait_valid("s3");
      chk("s3_feat", int'(feat_idx), f);
      chk("s3_lvl", int'(level_idx), exp_lv1[f]);
      chk("s3_score", int'(score), exp_sc1[f]);
      tick();
    end
    chk("s3_done", int'(done), 1);

    // Start while busy with a different query must be ignored.
    do_start(16'h0780);
    tick();
    tick();
    query_hv = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("s5", exp_lv1, exp_sc1, 1'b1);
    tick();
    tick();
    tick();
    chk("s5_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-scan.
    do_start(16'h0780);
    tick();
    tick();
    tick();
    chk("s6_pre_lvl", int'(level_idx), 1);
    chk("s6_pre_busy", int'(busy), 1);
    nrst = 1'b0;
    #1;
    chk("s6_rst_valid", int'(out_valid), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_done", int'(done), 0);
    chk("s6_rst_feat", int'(feat_idx), 0);
    chk("s6_rst_lvl", int'(level_idx), 0);
    chk("s6_rst_score", int'(score), 0);
    done_cnt = 0;
    tick();
    tick();
    tick();
    chk("s6_no_done", done_cnt, 0);
    chk("s6_no_valid", int'(out_valid), 0);
    nrst = 1'b1;
    tick();
    do_start(16'h0780);
    collect("s6", exp_lv1, exp_sc1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
